// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline hazard types: FSM state encoding and the stall-cause
// classification used by the controller and the trace logger.
package hazard_ctrl_pkg;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_FREEZE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    LOADUSE = 2'd1,
    BRANCH  = 2'd2,
    FREEZE  = 2'd3
  } stall_cause_t;

  // Priority: memory freeze, then taken branch (squashes the stalling
  // instruction), then load-use.
  function automatic stall_cause_t classify(input logic mem_wait,
                                            input logic branch_taken,
                                            input logic need_stall);
    if (mem_wait)          return FREEZE;
    else if (branch_taken) return BRANCH;
    else if (need_stall)   return LOADUSE;
    else                   return NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard responder: turns load-use, taken-branch and memory-wait
// conditions into PC/pipeline-register enables, flushes and bubbles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Need_Stall,
  input  logic             EX__Branch_Taken,
  input  logic             EXmem__MemEnable,
  input  logic             DMem_Ready,
  input  logic             Cnt_Clr,
  output logic             PC_WE,
  output logic             IFid__WE,
  output logic             IFid__Flush,
  output logic             IDex__WE,
  output logic             IDex__Bubble,
  output logic             EXmem__WE,
  output logic             MEMwb__WE,
  output logic             Bubble_Last,
  output logic             Freeze,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic [CNT_W-1:0] Freeze_Cnt
);

  localparam logic [CNT_W:0] TO_THRESH = (CNT_W + 1)'(MEM_TIMEOUT - 1);

  state_t         state;
  stall_cause_t   cause;
  logic           mem_wait;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W:0]   wait_inc;

  assign mem_wait = EXmem__MemEnable && !DMem_Ready;

  always_comb begin
    cause = rst ? NONE : classify(mem_wait, EX__Branch_Taken, Need_Stall);
    PC_WE        = 1'b1;
    IFid__WE     = 1'b1;
    IFid__Flush  = 1'b0;
    IDex__WE     = 1'b1;
    IDex__Bubble = 1'b0;
    EXmem__WE    = 1'b1;
    MEMwb__WE    = 1'b1;
    Freeze       = 1'b0;
    case (cause)
      FREEZE: begin
        PC_WE     = 1'b0;
        IFid__WE  = 1'b0;
        IDex__WE  = 1'b0;
        EXmem__WE = 1'b0;
        MEMwb__WE = 1'b0;
        Freeze    = 1'b1;
      end
      BRANCH: begin
        IFid__Flush  = 1'b1;
        IDex__Bubble = 1'b1;
      end
      LOADUSE: begin
        PC_WE        = 1'b0;
        IFid__WE     = 1'b0;
        IDex__Bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // The entry cycle (still in S_RUN) counts as freeze cycle 1, so after k
  // waiting cycles wait_cnt == k and the timeout flag shows in cycle MEM_TIMEOUT.
  always_comb begin
    wait_inc = '0;
    if (state == S_FREEZE) wait_inc = {1'b0, wait_cnt};
    wait_inc = wait_inc + (CNT_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      Bubble_Last <= 1'b0;
      Mem_Timeout <= 1'b0;
    end else begin
      state <= mem_wait ? S_FREEZE : S_RUN;
      if (mem_wait) begin
        wait_cnt <= wait_inc[CNT_W] ? '1 : wait_inc[CNT_W-1:0];
      end else begin
        wait_cnt    <= '0;
        Bubble_Last <= (cause == LOADUSE);
      end
      if (Cnt_Clr) begin
        Mem_Timeout <= 1'b0;
      end else if (mem_wait && (wait_inc >= TO_THRESH)) begin
        Mem_Timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cause == LOADUSE),
    .clr (Cnt_Clr),
    .q   (Stall_Cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cause == BRANCH),
    .clr (Cnt_Clr),
    .q   (Flush_Cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cause == FREEZE),
    .clr (Cnt_Clr),
    .q   (Freeze_Cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counters and a short timeout.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned CNT_W = 3;

  // {PC_WE, IFid__WE, IFid__Flush, IDex__WE, IDex__Bubble, EXmem__WE, MEMwb__WE, Freeze}
  localparam logic [7:0] C_NORM = 8'b1101_0110;
  localparam logic [7:0] C_LU   = 8'b0001_1110;
  localparam logic [7:0] C_BR   = 8'b1111_1110;
  localparam logic [7:0] C_FRZ  = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst, Need_Stall, EX__Branch_Taken, EXmem__MemEnable, DMem_Ready, Cnt_Clr;
  logic PC_WE, IFid__WE, IFid__Flush, IDex__WE, IDex__Bubble, EXmem__WE, MEMwb__WE;
  logic Bubble_Last, Freeze, Mem_Timeout;
  logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt, Freeze_Cnt;
  logic [7:0] ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign ctl = {PC_WE, IFid__WE, IFid__Flush, IDex__WE, IDex__Bubble,
                EXmem__WE, MEMwb__WE, Freeze};

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .Need_Stall       (Need_Stall),
    .EX__Branch_Taken (EX__Branch_Taken),
    .EXmem__MemEnable (EXmem__MemEnable),
    .DMem_Ready       (DMem_Ready),
    .Cnt_Clr          (Cnt_Clr),
    .PC_WE            (PC_WE),
    .IFid__WE         (IFid__WE),
    .IFid__Flush      (IFid__Flush),
    .IDex__WE         (IDex__WE),
    .IDex__Bubble     (IDex__Bubble),
    .EXmem__WE        (EXmem__WE),
    .MEMwb__WE        (MEMwb__WE),
    .Bubble_Last      (Bubble_Last),
    .Freeze           (Freeze),
    .Mem_Timeout      (Mem_Timeout),
    .Stall_Cnt        (Stall_Cnt),
    .Flush_Cnt        (Flush_Cnt),
    .Freeze_Cnt       (Freeze_Cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Need_Stall = 1'b0; EX__Branch_Taken = 1'b0;
    EXmem__MemEnable = 1'b0; DMem_Ready = 1'b0; Cnt_Clr = 1'b0;
    #2;
    chk("rst_cycle_ctl", 16'(ctl), 16'(C_NORM));
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_ctl", 16'(ctl), 16'(C_NORM));
    chk("after_rst_stall_cnt", 16'(Stall_Cnt), 16'd0);
    chk("after_rst_bubble_last", 16'(Bubble_Last), 16'd0);
    chk("after_rst_timeout", 16'(Mem_Timeout), 16'd0);

    // Load-use bubble
    tick();
    Need_Stall = 1'b1;
    #1 chk("lu_ctl", 16'(ctl), 16'(C_LU));
    tick();
    Need_Stall = 1'b0;
    #1;
    chk("lu_bubble_last", 16'(Bubble_Last), 16'd1);
    chk("lu_stall_cnt", 16'(Stall_Cnt), 16'd1);
    chk("lu_next_ctl", 16'(ctl), 16'(C_NORM));

    // Branch together with load-use request
    Cnt_Clr = 1'b1;
    tick();
    Cnt_Clr = 1'b0;
    EX__Branch_Taken = 1'b1; Need_Stall = 1'b1;
    #1 chk("br_ctl", 16'(ctl), 16'(C_BR));
    tick();
    EX__Branch_Taken = 1'b0; Need_Stall = 1'b0;
    #1;
    chk("br_flush_cnt", 16'(Flush_Cnt), 16'd1);
    chk("br_stall_cnt", 16'(Stall_Cnt), 16'd0);
    chk("br_bubble_last", 16'(Bubble_Last), 16'd0);

    // Load-use, then 3-cycle freeze with ignored branch/stall, then ready
    Cnt_Clr = 1'b1;
    tick();
    Cnt_Clr = 1'b0;
    Need_Stall = 1'b1;
    tick();
    Need_Stall = 1'b0; EXmem__MemEnable = 1'b1; DMem_Ready = 1'b0;
    #1;
    chk("frz1_ctl", 16'(ctl), 16'(C_FRZ));
    chk("frz1_bubble_last", 16'(Bubble_Last), 16'd1);
    tick();
    EX__Branch_Taken = 1'b1; Need_Stall = 1'b1;
    #1;
    chk("frz2_ctl", 16'(ctl), 16'(C_FRZ));
    chk("frz2_state", 16'(dut.state), 16'(S_FREEZE));
    chk("frz2_bubble_last", 16'(Bubble_Last), 16'd1);
    tick();
    EX__Branch_Taken = 1'b0; Need_Stall = 1'b0;
    #1 chk("frz3_ctl", 16'(ctl), 16'(C_FRZ));
    tick();
    DMem_Ready = 1'b1;
    #1;
    chk("ready_ctl", 16'(ctl), 16'(C_NORM));
    chk("ready_freeze_cnt", 16'(Freeze_Cnt), 16'd3);
    tick();
    EXmem__MemEnable = 1'b0; DMem_Ready = 1'b0;
    #1;
    chk("post_frz_state", 16'(dut.state), 16'(S_RUN));
    chk("post_frz_bubble_last", 16'(Bubble_Last), 16'd0);
    chk("post_frz_stall_cnt", 16'(Stall_Cnt), 16'd1);
    chk("post_frz_flush_cnt", 16'(Flush_Cnt), 16'd0);

    // Timeout with MEM_TIMEOUT=4 over a 6-cycle wait
    Cnt_Clr = 1'b1;
    tick();
    Cnt_Clr = 1'b0;
    EXmem__MemEnable = 1'b1; DMem_Ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1 chk($sformatf("to_cycle%0d", k), 16'(Mem_Timeout), (k >= 4) ? 16'd1 : 16'd0);
      tick();
    end
    DMem_Ready = 1'b1;
    #1;
    chk("to_ready", 16'(Mem_Timeout), 16'd1);
    chk("to_freeze_cnt", 16'(Freeze_Cnt), 16'd6);
    tick();
    EXmem__MemEnable = 1'b0; DMem_Ready = 1'b0;
    #1 chk("to_sticky", 16'(Mem_Timeout), 16'd1);
    Cnt_Clr = 1'b1;
    tick();
    Cnt_Clr = 1'b0;
    #1;
    chk("to_cleared", 16'(Mem_Timeout), 16'd0);
    chk("to_freeze_cnt_cleared", 16'(Freeze_Cnt), 16'd0);

    // Saturation and clear-beats-increment
    Need_Stall = 1'b1;
    repeat (9) tick();
    Need_Stall = 1'b0;
    #1 chk("sat_stall_cnt", 16'(Stall_Cnt), 16'd7);
    Need_Stall = 1'b1; Cnt_Clr = 1'b1;
    tick();
    Need_Stall = 1'b0; Cnt_Clr = 1'b0;
    #1;
    chk("clr_vs_inc", 16'(Stall_Cnt), 16'd0);
    chk("clr_vs_inc_bubble_last", 16'(Bubble_Last), 16'd1);

    // Reset in the middle of a freeze
    EXmem__MemEnable = 1'b1; DMem_Ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_freeze_cnt", 16'(Freeze_Cnt), 16'd2);
    chk("pre_rst_bubble_last", 16'(Bubble_Last), 16'd1);
    rst = 1'b1;
    #1 chk("rst_in_freeze_ctl", 16'(ctl), 16'(C_NORM));
    tick();
    rst = 1'b0; EXmem__MemEnable = 1'b0;
    #1;
    chk("rst_state", 16'(dut.state), 16'(S_RUN));
    chk("rst_ctl", 16'(ctl), 16'(C_NORM));
    chk("rst_freeze_cnt", 16'(Freeze_Cnt), 16'd0);
    chk("rst_stall_cnt", 16'(Stall_Cnt), 16'd0);
    chk("rst_flush_cnt", 16'(Flush_Cnt), 16'd0);
    chk("rst_bubble_last", 16'(Bubble_Last), 16'd0);
    chk("rst_timeout", 16'(Mem_Timeout), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
